// File: rtl/router_port_tx_if.sv
`default_nettype none
// ============================================================================
// router_port_tx_if : host-side request handshake (destination + payload byte)
// Revision: 1.0
// ============================================================================
interface router_port_tx_if;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_dest;
    logic [7:0] s_data;

    modport master (output s_valid, output s_dest, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_dest, input  s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/router_port_tx.sv
`default_nettype none
// ============================================================================
// router_port_tx : buffers host requests and serializes each one onto the
//                  router frame/valid/data lines (2 address bits, grant, 8 data)
// Revision: 1.0
// ============================================================================
module router_port_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    router_port_tx_if.slave                    host,
    output logic                               o_frame,
    output logic                               o_valid,
    output logic                               o_data,
    input  wire logic                          i_grant,
    output logic                               busy,
    output logic [15:0]                        pkt_cnt,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR0    = 3'd1,
        ADDR1    = 3'd2,
        WAIT_GNT = 3'd3,
        DATA     = 3'd4,
        GAP      = 3'd5
    } state_t;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [1:0]    dest_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          pkt_inc;
    logic          frame_q, frame_d;
    logic          valid_q, valid_d;
    logic          data_q, data_d;
    logic          busy_q, busy_d;
    logic [15:0]   pkt_cnt_q;

    assign host.s_ready = (count_q != LVL_FULL);
    assign push         = host.s_valid && host.s_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LVL_ONE;
        end else if (!push && pop) begin
            count_d = count_q - LVL_ONE;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host.s_dest, host.s_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        pkt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ADDR0;
                end
            end
            ADDR0: state_d = ADDR1;
            ADDR1, WAIT_GNT: begin
                if (i_grant) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d   = WAIT_GNT;
                end
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = GAP;
                    pkt_inc = 1'b1;
                end
            end
            GAP: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ADDR0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial lines are a registered image of the current state, one cycle behind it.
    always_comb begin
        frame_d = 1'b0;
        valid_d = 1'b0;
        data_d  = 1'b0;
        case (state_q)
            ADDR0: begin
                frame_d = 1'b1;
                data_d  = dest_q[0];
            end
            ADDR1, WAIT_GNT: begin
                frame_d = 1'b1;
                data_d  = dest_q[1];
            end
            DATA: begin
                frame_d = 1'b1;
                valid_d = 1'b1;
                data_d  = shift_q[bit_cnt_q];
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            dest_q    <= 2'd0;
            shift_q   <= 8'd0;
            frame_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            if (pop) begin
                {dest_q, shift_q} <= mem_q[rd_ptr_q];
            end
            if (pkt_inc) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign o_frame    = frame_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign busy       = busy_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign fifo_level = count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_port_tx.sv
`default_nettype none
// ============================================================================
// tb_router_port_tx : scoreboard bench; a negedge monitor decodes serial frames
// Revision: 1.0
// ============================================================================
module tb_router_port_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [1:0] d;
        logic [7:0] b;
    } req_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          o_frame, o_valid, o_data;
    logic          i_grant;
    logic          busy;
    logic [15:0]   pkt_cnt;
    logic [LW-1:0] fifo_level;

    router_port_tx_if hif ();

    router_port_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host       (hif),
        .o_frame    (o_frame),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_grant    (i_grant),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    req_t sb[$];
    int   rise_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // monitor state
    logic       prev_frame = 1'b0;
    bit         in_pkt = 1'b0;
    int         flen, vlen, nb;
    int         last_flen = 0, last_vlen = 0, pkts = 0;
    logic [7:0] byte_r;
    logic       a0, a1, last_a1;
    bit         a1set, hold_err;
    req_t       exp_r;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_frame = 1'b0;
            in_pkt     = 1'b0;
            nb         = 0;
        end else begin
            if (o_frame && !prev_frame) begin
                in_pkt = 1'b1; flen = 0; vlen = 0; nb = 0; byte_r = 8'h00;
                a1set = 1'b0; hold_err = 1'b0; a0 = 1'b0; a1 = 1'b0;
                rise_q.push_back(cyc);
            end
            if (o_frame && in_pkt) begin
                flen++;
                if (o_valid) begin
                    if (nb < 8) byte_r[nb] = o_data;
                    nb++;
                    vlen++;
                end else if (flen == 1) begin
                    a0 = o_data;
                end else if (!a1set) begin
                    a1 = o_data;
                    a1set = 1'b1;
                end else if (o_data !== a1 || nb != 0) begin
                    hold_err = 1'b1;
                end
            end
            if (!o_frame && prev_frame && in_pkt) begin
                in_pkt = 1'b0; last_flen = flen; last_vlen = vlen; last_a1 = a1;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_packet: got dest=%0d data=%h, required no packet", {a1, a0}, byte_r);
                end else begin
                    exp_r = sb.pop_front();
                    if ({a1, a0} !== exp_r.d || byte_r !== exp_r.b || hold_err || nb != 8) begin
                        n_fail++;
                        $display("FAIL mon_packet: got dest=%0d data=%h bits=%0d hold_err=%0d, required dest=%0d data=%h bits=8 hold_err=0",
                                 {a1, a0}, byte_r, nb, hold_err, exp_r.d, exp_r.b);
                    end
                end
                pkts++;
            end
            prev_frame = o_frame;
        end
    end

    int acc_cyc;

    task automatic push(input logic [1:0] d, input logic [7:0] b);
        int guard = 0;
        @(negedge clk); #1;
        hif.s_valid = 1'b1;
        hif.s_dest  = d;
        hif.s_data  = b;
        while (!hif.s_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!hif.s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: s_ready=0 for 200 cycles, required 1");
            hif.s_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge clk);
            sb.push_back('{d: d, b: b});
            #1 hif.s_valid = 1'b0;
        end
    endtask

    task automatic wait_pkts(input int target, output bit ok);
        int guard = 0;
        while (pkts < target && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        ok = (pkts >= target);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (o_frame !== 1'b0)    begin n_fail++; $display("FAIL reset_frame: got %b, required 0", o_frame); end
        n_checks++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
        n_checks++; if (o_data !== 1'b0)     begin n_fail++; $display("FAIL reset_data: got %b, required 0", o_data); end
        n_checks++; if (hif.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", hif.s_ready); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (pkt_cnt !== 16'd0)   begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
        n_checks++; if (fifo_level !== '0)   begin n_fail++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int base = pkts;
        logic [15:0] pc0 = pkt_cnt;
        i_grant = 1'b1;
        rise_q.delete();
        push(2'd3, 8'h55);
        wait_pkts(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done: got %0d packets, required %0d", pkts - base, 1); end
        n_checks++;
        if (rise_q.size() < 1 || rise_q[0] - acc_cyc != 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d edges, required 3", (rise_q.size() > 0) ? rise_q[0] - acc_cyc : -1);
        end
        n_checks++; if (last_flen != 10) begin n_fail++; $display("FAIL single_frame_len: got %0d, required 10", last_flen); end
        n_checks++; if (last_vlen != 8)  begin n_fail++; $display("FAIL single_valid_len: got %0d, required 8", last_vlen); end
        n_checks++; if (pkt_cnt !== pc0 + 16'd1) begin n_fail++; $display("FAIL single_pkt_cnt: got %0d, required %0d", pkt_cnt, pc0 + 16'd1); end
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, required 0", busy); end
    endtask

    task automatic test_delayed_grant();
        bit ok;
        int base = pkts;
        int guard = 0;
        int r;
        i_grant = 1'b0;
        rise_q.delete();
        push(2'd2, 8'hA3);
        while (rise_q.size() == 0 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        r = (rise_q.size() > 0) ? rise_q[0] : cyc;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL grant_busy: got %b, required 1", busy); end
        while (cyc < r + 5) begin
            @(negedge clk); #1;
        end
        n_checks++; if (o_frame !== 1'b1 || o_valid !== 1'b0 || o_data !== 1'b1) begin
            n_fail++; $display("FAIL grant_wait_lines: got frame=%b valid=%b data=%b, required 1 0 1", o_frame, o_valid, o_data);
        end
        i_grant = 1'b1;
        wait_pkts(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL grant_done: got %0d packets, required 1", pkts - base); end
        n_checks++; if (last_flen != 15) begin n_fail++; $display("FAIL grant_frame_len: got %0d, required 15", last_flen); end
        n_checks++; if (last_vlen != 8)  begin n_fail++; $display("FAIL grant_valid_len: got %0d, required 8", last_vlen); end
        n_checks++; if (last_a1 !== 1'b1) begin n_fail++; $display("FAIL grant_addr1: got %b, required 1", last_a1); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int base;
        logic [15:0] pc0;
        i_grant = 1'b0;
        base = pkts;
        pc0 = pkt_cnt;
        for (int i = 0; i < 5; i++) push(2'(i), 8'h10 + 8'(i * 17));
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL full_level: got %0d, required 4", fifo_level); end
        n_checks++; if (hif.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", hif.s_ready); end
        n_checks++; if (o_frame !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_wait: got frame=%b valid=%b, required 1 0", o_frame, o_valid);
        end
        hif.s_valid = 1'b1; hif.s_dest = 2'd1; hif.s_data = 8'hEE;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL full_hold: got %0d, required 4", fifo_level); end
        hif.s_valid = 1'b0;
        rise_q.delete();
        i_grant = 1'b1;
        wait_pkts(base + 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_done: got %0d packets, required 5", pkts - base); end
        n_checks++; if (pkt_cnt !== pc0 + 16'd5) begin n_fail++; $display("FAIL full_pkt_cnt: got %0d, required %0d", pkt_cnt, pc0 + 16'd5); end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (rise_q.size() < 4 || rise_q[i] - rise_q[i-1] != 11) begin
                n_fail++;
                $display("FAIL full_spacing%0d: got %0d, required 11", i, (rise_q.size() >= 4) ? rise_q[i] - rise_q[i-1] : -1);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int guard = 0;
        i_grant = 1'b1;
        push(2'd1, 8'hC7);
        push(2'd2, 8'h81);
        push(2'd0, 8'h42);
        while (!(in_pkt && nb == 4) && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        n_checks++; if (fifo_level !== LW'(2)) begin n_fail++; $display("FAIL mid_level_pre: got %0d, required 2", fifo_level); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (o_frame !== 1'b0 || o_valid !== 1'b0 || o_data !== 1'b0) begin
            n_fail++; $display("FAIL mid_lines: got %b%b%b, required 000", o_frame, o_valid, o_data);
        end
        n_checks++; if (fifo_level !== '0 || hif.s_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_fifo: got level=%0d ready=%b, required 0 1", fifo_level, hif.s_ready);
        end
        n_checks++; if (pkt_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_cnt: got pkt_cnt=%0d busy=%b, required 0 0", pkt_cnt, busy);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        push(2'd1, 8'h3C);
        wait_pkts(pkts + 1, ok);
        n_checks++; if (!ok || pkt_cnt !== 16'd1) begin
            n_fail++; $display("FAIL mid_after: got pkt_cnt=%0d, required 1", pkt_cnt);
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_sb: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_grant_drop();
        bit ok;
        int guard = 0;
        int base = pkts;
        logic [15:0] pc0 = pkt_cnt;
        i_grant = 1'b1;
        push(2'd0, 8'h96);
        while (!(in_pkt && nb == 2) && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        i_grant = 1'b0;
        wait_pkts(base + 1, ok);
        #1;
        n_checks++; if (!ok || last_vlen != 8) begin n_fail++; $display("FAIL drop_bits: got %0d, required 8", last_vlen); end
        n_checks++; if (o_frame !== 1'b0) begin n_fail++; $display("FAIL drop_gap: got frame=%b, required 0", o_frame); end
        n_checks++; if (pkt_cnt !== pc0 + 16'd1) begin n_fail++; $display("FAIL drop_pkt_cnt: got %0d, required %0d", pkt_cnt, pc0 + 16'd1); end
        i_grant = 1'b1;
    endtask

    initial begin
        hif.s_valid = 1'b0;
        hif.s_dest  = 2'd0;
        hif.s_data  = 8'd0;
        i_grant     = 1'b0;
        reset_n     = 1'b0;
        test_reset();
        test_single();
        test_delayed_grant();
        test_fifo_full();
        test_reset_mid();
        test_grant_drop();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
